wb_copy_master: RTL and testbench
=================================

# wb_copy_master

Wishbone classic single-transfer initiator that copies a block of 32-bit words from a source address range to a destination address range in the user area. It is the initiator counterpart of the team's Wishbone register-slave peripherals, such as the adder register block at the 0x3xxx_xxxx window. A command port launches each copy; the port is driven by logic-analyzer bits or by a local controller. Each copied word costs one Wishbone read followed by one Wishbone write.

## Interface
Parameters:
- `LEN_W`, default 8: width of the word-count field; maximum copy is 2^LEN_W−1 words.
- `TIMEOUT`, default 255: cycles `wbm_stb_o` may stay high without `wbm_ack_i` before the copy aborts. Used only with `WB_COPY_TIMEOUT_EN`.

Ports:
- `wb_clk_i`  in  1  single clock.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `cmd_valid_i`  in  1  copy request; sampled only when `cmd_ready_o`=1.
- `cmd_ready_o`  out  1  high in IDLE.
- `cmd_src_i`  in  32  source byte address; bits [1:0] are ignored and forced to 0.
- `cmd_dst_i`  in  32  destination byte address; bits [1:0] are ignored and forced to 0.
- `cmd_len_i`  in  LEN_W  number of words to copy.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone master controls.
- `wbm_sel_o`  out  4  byte select; always 4'hF during a transfer, 0 otherwise.
- `wbm_adr_o`  out  32  Wishbone address.
- `wbm_dat_o`  out  32  Wishbone write data.
- `wbm_dat_i`  in  32  Wishbone read data.
- `wbm_ack_i`  in  1  Wishbone acknowledge.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse at the end of a copy, whether successful or aborted.
- `err_o`  out  1  one-cycle pulse coincident with `done_o` when the copy is aborted by timeout.
- `words_o`  out  LEN_W  number of words fully written in the current or last copy.

## Operation
Reset values:
- All outputs are 0 except `cmd_ready_o`, which is 1.
- State is IDLE.
- `words_o` is 0.

States: IDLE, RD, RGAP, WR, WGAP, DONE.
- **IDLE**
  - If `cmd_valid_i` is high, latch src, dst and len, and clear `words_o`.
  - If len=0, go to DONE; otherwise go to RD.
- **RD**
  - Drive cyc=stb=1, we=0, adr=src.
  - On `wbm_ack_i`=1, capture `wbm_dat_i` into the data register and go to RGAP.
- **RGAP**
  - Drive cyc=stb=0; `wbm_ack_i` is ignored.
  - Go to WR.
- **WR**
  - Drive cyc=stb=we=1, adr=dst, `wbm_dat_o`=data register.
  - On ack, go to WGAP.
- **WGAP**
  - Drive cyc=stb=0.
  - Increment src and dst by 4, decrement the remaining count, increment `words_o`.
  - If remaining count is now 0, go to DONE; otherwise go to RD.
- **DONE**
  - Pulse `done_o`, then go to IDLE.

Rules:
- `wbm_ack_i` is sampled only while `wbm_stb_o`=1. The one-cycle GAP states absorb a registered slave ack that is still high for one cycle after stb drops.
- Address arithmetic wraps modulo 2^32. There is no boundary check.
- `wbm_adr_o` and `wbm_dat_o` hold their values while stb is low. Slaves must not rely on this.
- `cmd_valid_i` outside IDLE is ignored; commands are not queued.
- Reset asserted in any state:
  - On the next edge, go to IDLE with cyc and stb low.
  - The in-flight transfer is dropped.
  - Neither `done_o` nor `err_o` is pulsed.

## Timing
- Command acceptance: at the edge with IDLE and `cmd_valid_i`=1. `wbm_stb_o` rises in the next cycle.
- Against a slave that registers ack one cycle after stb:
  - Each read takes 3 cycles (RD, RD, RGAP).
  - Each write takes 3 cycles.
  - One word costs 6 cycles.
  - An N-word copy has `done_o` high 6N+1 cycles after acceptance.
- len=0: `done_o` is high in the cycle after acceptance, with no bus activity.
- `cmd_ready_o` returns high in the cycle after `done_o`. A new command can be accepted in that cycle.

## Configuration
- `WB_COPY_TIMEOUT_EN` defined:
  - A counter runs while stb=1 and clears when stb=0.
  - If it reaches `TIMEOUT` with no ack, drop cyc/stb on the next edge, go to DONE, and pulse `err_o` with `done_o`.
  - `words_o` keeps the count of words completed before the abort.
- `WB_COPY_TIMEOUT_EN` undefined:
  - No counter is built, `err_o` is tied to 0, and a missing ack stalls the copy indefinitely. Only reset recovers.

## Test plan
- 1-word copy, src=0x3000_0000 holding 0xDEAD_BEEF, dst=0x3000_0004, registered-ack slave model:
  - read at 0x3000_0000, then write 0xDEAD_BEEF at 0x3000_0004 with sel=4'hF.
  - `done_o` 7 cycles after acceptance; `words_o`=1.
- 4-word copy, src=0x3000_0010, dst=0x3000_0100, source values 1..4:
  - reads at 0x…10, 0x…14, 0x…18, 0x…1C, interleaved with writes at 0x…100 through 0x…10C.
  - destination equals 1..4; `done_o` at cycle 25; stb is never high in two consecutive transfers without a low cycle between them.
- len=0 with src=0x1234_5677: no cyc at all; `done_o` 1 cycle after acceptance; `words_o`=0.
- With `WB_COPY_TIMEOUT_EN`, TIMEOUT=16, slave never acks on a 2-word copy: stb high for 16 cycles, then `err_o`=`done_o`=1, cyc=0, `words_o`=0.
- `wb_rst_i` pulsed for 1 cycle during the WR state of word 2 of a 3-word copy: cyc=stb=0 next cycle, `busy_o`=0, `words_o`=0, no `done_o` pulse.
- `cmd_valid_i` held high throughout a 2-word copy with different fields: the second command is accepted only in the cycle after `done_o`, and the original copy's addresses are unaffected.

Source files
------------

// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone classic initiator copying 32-bit words src->dst.
// Define WB_COPY_TIMEOUT_EN to build the missing-ack timeout abort.
module wb_copy_master #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_src_i,
  input  logic [31:0]      cmd_dst_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RGAP = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_WGAP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [31:0]      adr_q;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] words_q;
  logic             err_q;
  logic             stb;
  logic             timeout_hit;
  logic             unused_ok;

  assign stb = (state == S_RD) || (state == S_WR);

  assign wbm_cyc_o   = stb;
  assign wbm_stb_o   = stb;
  assign wbm_we_o    = (state == S_WR);
  assign wbm_sel_o   = stb ? 4'hF : 4'h0;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = data_q;
  assign cmd_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign err_o       = (state == S_DONE) && err_q;
  assign words_o     = words_q;

  // low address bits are forced to zero, so they never reach the datapath
  assign unused_ok = ^{cmd_src_i[1:0], cmd_dst_i[1:0], (TIMEOUT > 0)};

`ifdef WB_COPY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // count stalled strobe cycles; any ack or idle bus clears it
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      tcnt <= '0;
    else if (stb && !wbm_ack_i)
      tcnt <= tcnt + TW'(1);
    else
      tcnt <= '0;
  end

  assign timeout_hit = stb && !wbm_ack_i &&
                       (tcnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // copy sequencer: one read, one write, a gap cycle after each
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      src     <= '0;
      dst     <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      rem     <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            src     <= {cmd_src_i[31:2], 2'b00};
            dst     <= {cmd_dst_i[31:2], 2'b00};
            adr_q   <= {cmd_src_i[31:2], 2'b00};
            rem     <= cmd_len_i;
            words_q <= '0;
            err_q   <= 1'b0;
            state   <= (cmd_len_i == '0) ? S_DONE : S_RD;
          end
        end
        S_RD: begin
          if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (wbm_ack_i) begin
            data_q <= wbm_dat_i;
            state  <= S_RGAP;
          end
        end
        S_RGAP: begin
          adr_q <= dst;
          state <= S_WR;
        end
        S_WR: begin
          if (timeout_hit) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (wbm_ack_i) begin
            state <= S_WGAP;
          end
        end
        S_WGAP: begin
          src     <= src + 32'd4;
          dst     <= dst + 32'd4;
          adr_q   <= src + 32'd4;
          rem     <= rem - LEN_W'(1);
          words_q <= words_q + LEN_W'(1);
          state   <= (rem == LEN_W'(1)) ? S_DONE : S_RD;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// tb_wb_copy_master: scoreboard bench with memory slave and copy model.
// Timeout scenario runs only when WB_COPY_TIMEOUT_EN is defined.
module tb_wb_copy_master;

  localparam int LEN_W = 8;
  localparam int TOUT  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_src = '0;
  logic [31:0]      cmd_dst = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cyc, stb, we;
  logic [3:0]       sel;
  logic [31:0]      adr, dat_o;
  logic [31:0]      dat_i = '0;
  logic             ack = 1'b0;
  logic             busy, done, err;
  logic [LEN_W-1:0] words;

  wb_copy_master #(.LEN_W(LEN_W), .TIMEOUT(TOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy_o(busy), .done_o(done), .err_o(err), .words_o(words)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] adr; logic [31:0] dat; } xfer_t;
  typedef struct { int cyc; int words; bit err; } done_t;

  xfer_t       bus_q[$];
  done_t       done_q[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int cyc_cnt = 0;
  bit mute = 0;
  bit linger = 0;
  bit prev_x = 0;
  bit xfer;
  xfer_t e;
  done_t dq;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got event expected none/in-time", name);
  endtask

  always @(posedge clk) cyc_n++;

  // registered-ack memory slave; optionally holds ack one extra cycle
  always @(posedge clk) begin
    if (cyc && stb && ack) begin
      if (we) mem[adr] = dat_o;
      ack <= linger;
    end else if (cyc && stb && !mute) begin
      ack <= 1'b1;
      if (!we) dat_i <= slv_rd(adr);
    end else begin
      ack <= 1'b0;
    end
  end

  // monitor: compares completed transfers and done pulses to the queues
  always @(negedge clk) begin
    if (!rst) begin
      xfer = cyc && stb && ack;
      if (cyc) cyc_cnt++;
      if (prev_x) check("stb_gap", {31'd0, stb}, 32'd0);
      if (stb) check("sel", {28'd0, sel}, 32'hF);
      if (xfer) begin
        if (bus_q.size() == 0) fail_now("bus_unexpected");
        else begin
          e = bus_q.pop_front();
          check("bus_we", {31'd0, we}, {31'd0, e.we});
          check("bus_adr", adr, e.adr);
          check("bus_dat", we ? dat_o : dat_i, e.dat);
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail_now("done_unexpected");
        else begin
          dq = done_q.pop_front();
          check("done_cycle", cyc_n, dq.cyc);
          check("done_words", {24'd0, words}, dq.words);
          check("done_err", {31'd0, err}, {31'd0, dq.err});
          check("done_cyc_low", {31'd0, cyc}, 32'd0);
        end
      end
      if (err && !done) fail_now("err_without_done");
      prev_x = xfer;
    end else begin
      prev_x = 0;
    end
  end

  task automatic push_words(input logic [31:0] s, input logic [31:0] d,
                            input int n, input bit extra_read);
    logic [31:0] a, b, v;
    xfer_t x;
    a = {s[31:2], 2'b00};
    b = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      v = ref_rd(a);
      x.we = 0; x.adr = a; x.dat = v; bus_q.push_back(x);
      ref_mem[b] = v;
      x.we = 1; x.adr = b; x.dat = v; bus_q.push_back(x);
      a += 32'd4;
      b += 32'd4;
    end
    if (extra_read) begin
      x.we = 0; x.adr = a; x.dat = ref_rd(a); bus_q.push_back(x);
    end
  endtask

  task automatic push_done(input int c, input int w, input bit er);
    done_t x;
    x.cyc = c; x.words = w; x.err = er;
    done_q.push_back(x);
  endtask

  task automatic expect_copy(input logic [31:0] s, input logic [31:0] d,
                             input int len, input int acc);
    push_words(s, d, len, 0);
    push_done(acc + 6 * len + 1, len, 0);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
  endtask

  // mode 0: normal copy, 1: timeout abort, 2: caller pushes expectations
  task automatic issue(input logic [31:0] s, input logic [31:0] d,
                       input int len, input int mode, output int acc);
    @(negedge clk);
    cmd_src = s; cmd_dst = d; cmd_len = LEN_W'(len);
    cmd_valid = 1'b1;
    wait_ready();
    acc = cyc_n;
    if (mode == 0) expect_copy(s, d, len, acc);
    if (mode == 1) push_done(acc + 1 + TOUT, 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((bus_q.size() != 0 || done_q.size() != 0 || !cmd_ready)
           && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) fail_now("copy_complete_timeout");
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, len, b0;
    logic [31:0] s, d;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("rst_we_sel", {27'd0, we, sel}, 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_words", {24'd0, words}, 32'd0);
    rst = 1'b0;

    preload(32'h3000_0000, 32'hDEAD_BEEF);
    issue(32'h3000_0000, 32'h3000_0004, 1, 0, acc);
    wait_done();
    check("w1_dst", mem[32'h3000_0004], 32'hDEAD_BEEF);
    check("w1_words", {24'd0, words}, 32'd1);

    for (int i = 0; i < 4; i++)
      preload(32'h3000_0010 + 32'(4 * i), 32'(i + 1));
    issue(32'h3000_0010, 32'h3000_0100, 4, 0, acc);
    wait_done();
    for (int i = 0; i < 4; i++)
      check("w4_dst", slv_rd(32'h3000_0100 + 32'(4 * i)), 32'(i + 1));
    check("w4_words", {24'd0, words}, 32'd4);

    b0 = cyc_cnt;
    issue(32'h1234_5677, 32'h3000_0200, 0, 0, acc);
    wait_done();
    check("len0_no_cyc", 32'(cyc_cnt), 32'(b0));
    check("len0_words", {24'd0, words}, 32'd0);

`ifdef WB_COPY_TIMEOUT_EN
    mute = 1;
    issue(32'h3000_0400, 32'h3000_0500, 2, 1, acc);
    wait_done();
    mute = 0;
    check("to_words", {24'd0, words}, 32'd0);
    repeat (2) @(negedge clk);
`endif

    push_words(32'h3000_0600, 32'h3000_0700, 1, 1);
    issue(32'h3000_0600, 32'h3000_0700, 3, 2, acc);
    b0 = 0;
    while (cyc_n < acc + 10 && b0 < 100) begin
      @(negedge clk);
      b0++;
    end
    check("rst_mid_we", {31'd0, we}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_words", {24'd0, words}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_mid_bus_q", 32'(bus_q.size()), 32'd0);

    @(negedge clk);
    cmd_src = 32'h3000_0800; cmd_dst = 32'h3000_0900;
    cmd_len = LEN_W'(2); cmd_valid = 1'b1;
    wait_ready();
    acc = cyc_n;
    expect_copy(32'h3000_0800, 32'h3000_0900, 2, acc);
    @(negedge clk);
    cmd_src = 32'h3000_0A00; cmd_dst = 32'h3000_0B00;
    cmd_len = LEN_W'(3);
    wait_ready();
    acc2 = cyc_n;
    check("hold_accept_cycle", 32'(acc2), 32'(acc + 14));
    expect_copy(32'h3000_0A00, 32'h3000_0B00, 3, acc2);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done();

    linger = 1;
    issue(32'hFFFF_FFF8, 32'h3000_0C00, 4, 0, acc);
    wait_done();

    for (int t = 0; t < 25; t++) begin
      s = 32'h3000_0000 + 32'($urandom_range(0, 63) << 2)
          + 32'($urandom_range(0, 3));
      d = 32'h3000_0000 + 32'($urandom_range(0, 63) << 2)
          + 32'($urandom_range(0, 3));
      len = $urandom_range(0, 6);
      linger = 1'($urandom_range(0, 1));
      issue(s, d, len, 0, acc);
      wait_done();
      check("rand_words", {24'd0, words}, 32'(len));
    end

    check("end_bus_q", 32'(bus_q.size()), 32'd0);
    check("end_done_q", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
